// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the sequencer state encoding, requester indices and the
// round-robin pick function used by rr_arb2.
package mem_arb_pkg;

  // Access sequencer states: wait for a request, drive the memory, return data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Requester indices into the req/gnt/ack vectors.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Two-way round-robin pick: a lone requester always wins; on a tie the
  // requester that did not win last time is chosen. Returns a one-hot grant
  // (or zero when nobody is asking).
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       last_grant);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker plus the register that
// remembers which requester was granted last. The last-grant register only
// moves when the caller accepts the grant, so a grant offered while the
// sequencer is busy does not disturb fairness.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick the winner from the current requests and the previous winner.
  always_comb begin
    gnt_o = rr_pick(req_i, last_grant_q);
  end

  // Remember the winner only when the grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[REQ_DBG];
    end
  end

  // Out of reset the debug port counts as the last winner, so the CPU wins
  // the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU (port 0) and front-panel debug (port 1)
// accesses onto a single-port synchronous memory. Each access takes three
// cycles: IDLE (grant and register the command), ISSUE (memory samples the
// address, write strobe high for this cycle only), DONE (one-cycle ack, read
// data passed straight through from the memory).
// Optional build macro MEM_ARB_LOCK_EN adds a lock0 input that, while high,
// reserves the memory for the CPU so it can perform read-modify-write
// sequences without the debug port slipping in between.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  lock0,
`endif
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_we_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [1:0]              ack_q;
  logic                    owner_q;
  logic                    busy_q;

  logic [1:0]              req_vec;
  logic [1:0]              gnt;
  logic                    grant_accept;
  logic                    last_grant;

  // Requests seen by the picker. With the lock feature, a held lock0 hides
  // the debug request entirely so it cannot win even on its turn.
`ifdef MEM_ARB_LOCK_EN
  always_comb begin
    req_vec = {req1 & ~lock0, req0};
  end
`else
  always_comb begin
    req_vec = {req1, req0};
  end
`endif

  // Grants are only taken in IDLE; requests elsewhere are ignored, not queued.
  assign grant_accept = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_vec),
    .accept_i     (grant_accept),
    .gnt_o        (gnt),
    .last_grant_o (last_grant)
  );

  // Access sequencer with registered memory controls, ack and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      ack_q       <= 2'b00;
      owner_q     <= REQ_CPU;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (gnt[REQ_DBG]) begin
            mem_addr_q  <= addr1;
            mem_we_q    <= we1;
            mem_wdata_q <= wdata1;
            owner_q     <= REQ_DBG;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end else if (gnt[REQ_CPU]) begin
            mem_addr_q  <= addr0;
            mem_we_q    <= we0;
            mem_wdata_q <= wdata0;
            owner_q     <= REQ_CPU;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // The memory samples address/data/strobe at the end of this cycle;
          // drop the strobe so a write lands exactly once.
          mem_we_q       <= 1'b0;
          ack_q[owner_q] <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ack0      = ack_q[REQ_CPU];
  assign ack1      = ack_q[REQ_DBG];
  assign busy      = busy_q;
  assign owner     = owner_q;

  // Read data is routed only to the port being acknowledged; the other port
  // sees zero so stale memory output never leaks across requesters.
  always_comb begin
    rdata0 = ack_q[REQ_CPU] ? mem_rdata : '0;
    rdata1 = ack_q[REQ_DBG] ? mem_rdata : '0;
  end

  // The last-grant value is kept inside the picker; it is not needed here
  // beyond confirming the picker's state is live.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// rounds, checked against a queue-based transaction model and a shadow copy
// of the memory contents.
module tb_mem_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, owner, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
  logic          lock0 = 1'b0;
`endif

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          mem_fill = 1'b1;

  cmd_t q0[$];
  cmd_t q1[$];
  int   last_w  = 1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MEM_ARB_LOCK_EN
    .lock0     (lock0),
`endif
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  // Single-port synchronous memory: write on strobe, registered read.
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic we, input int addr, input logic [DW-1:0] d);
    cmd_t c;
    c.we   = we;
    c.addr = AW'(addr);
    c.data = d;
    if (port == 0) q0.push_back(c);
    else           q1.push_back(c);
  endtask

  // Present the head of each queue on its port, or drop the request.
  task automatic present();
    req0 = (q0.size() > 0);
    req1 = (q1.size() > 0);
    if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
    if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
  endtask

  // Serve everything queued. The model picks the winner from the fairness
  // rule, then expects the ack exactly three cycles after the request is
  // first seen in IDLE, with correct owner, write strobe count and data.
  task automatic run_queues();
    bit   p0, p1, got;
    int   w, lat, we_cnt;
    cmd_t c;
    present();
    while (q0.size() > 0 || q1.size() > 0) begin
      p0 = (q0.size() > 0);
      p1 = (q1.size() > 0);
`ifdef MEM_ARB_LOCK_EN
      if (lock0 && !p0) lock0 = 1'b0;
`endif
      if (p0 && p1) w = 1 - last_w;
      else          w = p0 ? 0 : 1;
`ifdef MEM_ARB_LOCK_EN
      if (lock0 && p0) w = 0;
`endif
      c      = (w == 0) ? q0[0] : q1[0];
      got    = 0;
      lat    = 0;
      we_cnt = 0;
      for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
        @(negedge clk);
        if (mem_we) we_cnt++;
        check("nonowner_ack", (w == 0) ? ack1 : ack0, 0);
        if ((w == 0 && ack0) || (w == 1 && ack1)) begin
          got = 1;
          lat = cyc;
        end
      end
      check("ack_seen", got, 1);
      check("ack_latency", lat, 3);
      check("owner", owner, w);
      check("busy_in_done", busy, 1);
      check("we_pulses", we_cnt, c.we ? 1 : 0);
      check("nonowner_rdata", (w == 0) ? rdata1 : rdata0, 0);
      if (!c.we) check("rdata", (w == 0) ? rdata0 : rdata1, exp_mem[c.addr]);
      else       exp_mem[c.addr] = c.data;
      $display("txn port=%0d we=%0d addr=0x%02h data=0x%04h lat=%0d", w, c.we, c.addr,
               c.we ? c.data : ((w == 0) ? rdata0 : rdata1), lat);
      last_w = w;
      if (w == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      present();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
    repeat (3) step();
    mem_fill = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Simultaneous reads after reset: CPU first, then debug.
    last_w = 1;
    push(0, 1'b0, 6'h01, 16'h0);
    push(1, 1'b0, 6'h02, 16'h0);
    run_queues();

    // CPU write then read back.
    push(0, 1'b1, 6'h05, 16'hBEEF);
    push(0, 1'b0, 6'h05, 16'h0);
    run_queues();
    check("cpu_readback", exp_mem[5], 16'hBEEF);

    // Sustained contention: three accesses per port, strict alternation.
    for (int i = 0; i < 3; i++) begin
      push(0, i[0], 8 + i, 16'hA000 + 16'(i));
      push(1, 1'b0, 20 + i, 16'h0);
    end
    run_queues();

    // Debug write at the top address, then CPU read.
    push(1, 1'b1, 6'h3F, 16'h1234);
    run_queues();
    push(0, 1'b0, 6'h3F, 16'h0);
    run_queues();

    // Reset in the middle of a write's ISSUE cycle.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h10; wdata0 = 16'hAAAA;
    step();
    check("issue_we", mem_we, 1);
    check("issue_addr", mem_addr, 6'h10);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_ack0", ack0, 0);
    check("abort_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack", {ack1, ack0}, 0);
    end
    rst = 1'b0;
    last_w = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_no_ack", {ack1, ack0}, 0);
    end
    step();
    push(0, 1'b0, 6'h10, 16'h0);
    run_queues();

`ifdef MEM_ARB_LOCK_EN
    // Lock held: three CPU grants despite a waiting debug request, then debug.
    step();
    lock0 = 1'b1;
    for (int i = 0; i < 3; i++) push(0, 1'b0, 30 + i, 16'h0);
    push(1, 1'b0, 40, 16'h0);
    run_queues();
    check("lock_released_owner", owner, 1);
`endif

    // Random rounds.
    for (int r = 0; r < 12; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        push(0, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 16'($urandom));
      for (int i = 0; i < n1; i++)
        push(1, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 16'($urandom));
      run_queues();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
